clock_ctrl: RTL

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_pkg.sv | 40 ++++
 rtl/key_sync.sv | 32 +++
 rtl/clock_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types, field limits and BCD helpers for the clock_ctrl slice.
package clock_pkg;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StSetH = 2'd1,
    StSetM = 2'd2,
    StSetS = 2'd3
  } mode_e;

  localparam int unsigned HourLimit   = 24;
  localparam int unsigned MinSecLimit = 60;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // True when v is at (or, defensively, beyond) the last legal value below limit.
  function automatic logic bcd_is_last(bcd_t v, int unsigned limit);
    logic [7:0] last;
    last = {4'((limit - 1) / 10), 4'((limit - 1) % 10)};
    return {v.tens, v.ones} >= last;
  endfunction

  function automatic bcd_t bcd_inc(bcd_t v, int unsigned limit);
    bcd_t r;
    if (bcd_is_last(v, limit)) begin
      r = '0;
    end else if (v.ones >= 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.tens = v.tens;
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer plus falling-edge detector for one active-low pushbutton.
module key_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [1:0] fill_q;
  logic       armed_q;

  // Armed only after a genuine released level has passed the synchronizer, so a key
  // held through reset deassertion never looks like a fresh press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_ni};
      prev_q  <= sync_q[1];
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & sync_q[1]);
    end
  end

  assign press_o = armed_q & prev_q & ~sync_q[1];

endmodule

// File: rtl/clock_ctrl.sv
// 24-hour BCD clock with a seconds prescaler and a RUN/SET_H/SET_M/SET_S key-driven editor.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DIV = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sw_hold,
  output logic       sec_tick,
  output logic       day_pulse,
  output logic [1:0] mode,
  output logic [3:0] hh_t,
  output logic [3:0] hh_o,
  output logic [3:0] mm_t,
  output logic [3:0] mm_o,
  output logic [3:0] ss_t,
  output logic [3:0] ss_o
);

  localparam logic [31:0] DivLast = 32'(DIV - 1);

  mode_e       state_q, state_d;
  logic [31:0] presc_q, presc_d;
  bcd_t        hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic        tick_q, tick_d, day_q, day_d;
  logic [1:0]  hold_sync_q;
  logic        mode_evt, inc_evt, inc_ok, hold;

  key_sync u_key_mode (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .key_ni  (key_mode),
    .press_o (mode_evt)
  );

  key_sync u_key_inc (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .key_ni  (key_inc),
    .press_o (inc_evt)
  );

  assign hold   = hold_sync_q[1];
  assign inc_ok = inc_evt & ~mode_evt;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    tick_d  = 1'b0;
    day_d   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mode_evt) state_d = StSetH;
        if (!hold) begin
          if (presc_q >= DivLast) begin
            presc_d = '0;
            tick_d  = 1'b1;
            ss_d    = bcd_inc(ss_q, MinSecLimit);
            if (bcd_is_last(ss_q, MinSecLimit)) begin
              mm_d = bcd_inc(mm_q, MinSecLimit);
              if (bcd_is_last(mm_q, MinSecLimit)) begin
                hh_d  = bcd_inc(hh_q, HourLimit);
                day_d = bcd_is_last(hh_q, HourLimit);
              end
            end
          end else begin
            presc_d = presc_q + 32'd1;
          end
        end
      end
      StSetH: begin
        if (mode_evt) state_d = StSetM;
        presc_d = '0;
        if (inc_ok) hh_d = bcd_inc(hh_q, HourLimit);
      end
      StSetM: begin
        if (mode_evt) state_d = StSetS;
        presc_d = '0;
        if (inc_ok) mm_d = bcd_inc(mm_q, MinSecLimit);
      end
      StSetS: begin
        if (mode_evt) state_d = StRun;
        presc_d = '0;
        if (inc_ok) ss_d = bcd_inc(ss_q, MinSecLimit);
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRun;
      presc_q     <= '0;
      hh_q        <= '0;
      mm_q        <= '0;
      ss_q        <= '0;
      tick_q      <= 1'b0;
      day_q       <= 1'b0;
      hold_sync_q <= 2'b11;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      tick_q      <= tick_d;
      day_q       <= day_d;
      hold_sync_q <= {hold_sync_q[0], sw_hold};
    end
  end

  always_comb begin
    mode      = state_q;
    sec_tick  = tick_q;
    day_pulse = day_q;
    hh_t      = hh_q.tens;
    hh_o      = hh_q.ones;
    mm_t      = mm_q.tens;
    mm_o      = mm_q.ones;
    ss_t      = ss_q.tens;
    ss_o      = ss_q.ones;
  end

endmodule
